// File: rtl/keypad_pkg.sv
// Shared types, constants and keymap for the keypad front end.
// Used by keypad_col_scan and keypad_scan.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAND,
    LATCH,
    PRESS
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } scan_res_t;

  localparam logic [3:0] KEY_CODESET = 4'hA;

  // row 0: 1 2 3 A / row 1: 4 5 6 B
  // row 2: 7 8 9 C / row 3: E 0 F D
  function automatic logic [3:0] key_code(
    input logic [1:0] row,
    input logic [1:0] col
  );
    logic [3:0] c;
    unique case ({row, col})
      4'h0: c = 4'h1;
      4'h1: c = 4'h2;
      4'h2: c = 4'h3;
      4'h3: c = 4'hA;
      4'h4: c = 4'h4;
      4'h5: c = 4'h5;
      4'h6: c = 4'h6;
      4'h7: c = 4'hB;
      4'h8: c = 4'h7;
      4'h9: c = 4'h8;
      4'hA: c = 4'h9;
      4'hB: c = 4'hC;
      4'hC: c = 4'hE;
      4'hD: c = 4'h0;
      4'hE: c = 4'hF;
      default: c = 4'hD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Row synchronizer, column sequencer and per-scan hit accounting.
// Ports: clk, n_rst, row_in -> col_out, scan_done, result, code.
module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic      clk,
  input  logic      n_rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic      scan_done,
  output scan_res_t result,
  output logic [3:0] code
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_MAX =
    DW'(SCAN_DIV - 1);

  logic [3:0]    row_s1;
  logic [3:0]    row_s2;
  logic [DW-1:0] div_cnt;
  logic [1:0]    col;
  logic [1:0]    hits;
  logic [1:0]    hits_n;
  logic [3:0]    first;
  logic [3:0]    first_n;
  logic          sample;

  assign sample = (div_cnt == DIV_MAX);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      row_s1  <= 4'hF;
      row_s2  <= 4'hF;
      div_cnt <= '0;
      col     <= 2'd0;
      hits    <= 2'd0;
      first   <= 4'h0;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
      if (sample) begin
        div_cnt <= '0;
        col     <= col + 2'd1;
        // last column closes the scan
        if (col == 2'd3) begin
          hits  <= 2'd0;
          first <= 4'h0;
        end else begin
          hits  <= hits_n;
          first <= first_n;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // fold this column's rows into the
  // saturating hit count
  always_comb begin
    hits_n  = hits;
    first_n = first;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2[r]) begin
        if (hits_n == 2'd0)
          first_n = key_code(2'(r), col);
        if (hits_n != 2'd3)
          hits_n = hits_n + 2'd1;
      end
    end
  end

  always_comb begin
    result = MULTI;
    if (hits_n == 2'd0)
      result = NONE;
    else if (hits_n == 2'd1)
      result = SINGLE;
  end

  assign scan_done = sample && (col == 2'd3);
  assign code      = first_n;
  assign col_out   = ~(4'b0001 << col);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with debounce and multi-key rejection.
// Ports: clk, n_rst, row_in -> col_out, keyValue, keySured, codeSet_t.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] keyValue,
  output logic       keySured,
  output logic       codeSet_t
);

  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DEB_MAX =
    DW'(DEBOUNCE_SCANS);

  logic      scan_done;
  scan_res_t result;
  logic [3:0] code;

  state_t        state;
  state_t        state_n;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] deb_n;
  logic [3:0]    cand_code;
  logic [3:0]    cand_n;
  logic [3:0]    kv_n;

  keypad_col_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk      (clk),
    .n_rst    (n_rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .scan_done(scan_done),
    .result   (result),
    .code     (code)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      deb_cnt   <= '0;
      cand_code <= 4'h0;
      keyValue  <= 4'h0;
      keySured  <= 1'b0;
      codeSet_t <= 1'b0;
    end else begin
      state     <= state_n;
      deb_cnt   <= deb_n;
      cand_code <= cand_n;
      keyValue  <= kv_n;
      keySured  <= (state == PRESS) &&
                   (keyValue != KEY_CODESET);
      codeSet_t <= (state == PRESS) &&
                   (keyValue == KEY_CODESET);
    end
  end

  always_comb begin
    state_n = state;
    deb_n   = deb_cnt;
    cand_n  = cand_code;
    kv_n    = keyValue;
    unique case (state)
      IDLE: begin
        if (scan_done && result == SINGLE) begin
          cand_n = code;
          deb_n  = DW'(1);
          state_n = (DEBOUNCE_SCANS == 1) ?
                    LATCH : CAND;
        end
      end
      CAND: begin
        if (scan_done) begin
          if (result == SINGLE &&
              code == cand_code) begin
            deb_n = deb_cnt + 1'b1;
            if (deb_n == DEB_MAX)
              state_n = LATCH;
          end else if (result == SINGLE) begin
            cand_n = code;
            deb_n  = DW'(1);
          end else begin
            deb_n   = '0;
            state_n = IDLE;
          end
        end
      end
      // a scan completing here is dropped
      LATCH: begin
        kv_n    = cand_code;
        deb_n   = '0;
        state_n = PRESS;
      end
      PRESS: begin
        if (scan_done) begin
          if (result == NONE) begin
            deb_n = deb_cnt + 1'b1;
            if (deb_n == DEB_MAX) begin
              deb_n   = '0;
              state_n = IDLE;
            end
          end else begin
            deb_n = '0;
          end
        end
      end
      default: begin
        deb_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_SCANS=2.
// A keypad model drives row_in from the pressed-key mask and col_out.
module tb_keypad_scan;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  kv;
    logic        sured;
    logic        cset;
  } vec_t;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_value;
  logic        key_sured;
  logic        code_set;
  logic [15:0] keys;
  int          total = 0;
  int          bad = 0;
  int          cyc;
  logic [3:0]  prev;
  vec_t        vecs[8];

  always #5 clk = ~clk;

  keypad_scan #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .keyValue (key_value),
    .keySured (key_sured),
    .codeSet_t(code_set)
  );

  // key (r,c) is bit r*4+c of keys
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c])
          row_in[r] = 1'b0;
  end

  // posedges since reset release
  always @(posedge clk or negedge n_rst)
    if (!n_rst) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // stop just after a scan completion edge
  task automatic align();
    @(negedge clk);
    for (int i = 0; i < 16; i++)
      if (cyc % 16 != 0) @(negedge clk);
  endtask

  // called on a negedge just after a scan end
  task automatic press_check(input logic [15:0] k,
                             input logic [3:0] pv,
                             input logic [3:0] kv,
                             input logic s,
                             input logic cs);
    keys = k;
    step(32);
    chk("pre_kv", int'(key_value), int'(pv));
    chk("pre_strobe", int'({key_sured, code_set}), 0);
    step(1);
    chk("lat_kv", int'(key_value), int'(kv));
    chk("lat_strobe", int'({key_sured, code_set}), 0);
    step(1);
    chk("sured", int'(key_sured), int'(s));
    chk("codeset", int'(code_set), int'(cs));
  endtask

  task automatic release_check(input logic [3:0] kv,
                               input logic s,
                               input logic cs);
    align();
    chk("hold_sured", int'(key_sured), int'(s));
    chk("hold_cset", int'(code_set), int'(cs));
    keys = 16'h0;
    step(32);
    chk("rel_pre", int'({key_sured, code_set}),
        int'({s, cs}));
    step(1);
    chk("rel_strobe", int'({key_sured, code_set}), 0);
    chk("rel_kv", int'(key_value), int'(kv));
  endtask

  initial begin
    logic       saw;
    logic [3:0] e;
    vecs[0] = '{16'h0020, 4'h5, 1'b1, 1'b0};
    vecs[1] = '{16'h0008, 4'hA, 1'b0, 1'b1};
    vecs[2] = '{16'h2000, 4'h0, 1'b1, 1'b0};
    vecs[3] = '{16'h4000, 4'hF, 1'b1, 1'b0};
    vecs[4] = '{16'h1000, 4'hE, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 4'hD, 1'b1, 1'b0};
    vecs[6] = '{16'h0400, 4'h9, 1'b1, 1'b0};
    vecs[7] = '{16'h0080, 4'hB, 1'b1, 1'b0};

    keys  = 16'h0;
    n_rst = 1'b0;
    step(3);
    chk("rst_kv", int'(key_value), 0);
    chk("rst_sured", int'(key_sured), 0);
    chk("rst_cset", int'(code_set), 0);
    chk("rst_col", int'(col_out), 14);
    n_rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      e = ~(4'b0001 << (i / 4));
      chk("col_seq", int'(col_out), int'(e));
      step(1);
    end

    prev = 4'h0;
    for (int i = 0; i < 8; i++) begin
      align();
      press_check(vecs[i].keys, prev, vecs[i].kv,
                  vecs[i].sured, vecs[i].cset);
      step(48);
      release_check(vecs[i].kv, vecs[i].sured,
                    vecs[i].cset);
      prev = vecs[i].kv;
    end

    // bouncing '5': never two SINGLE scans in a row
    align();
    saw = 1'b0;
    for (int t = 0; t < 48; t++) begin
      keys = ((t / 10) % 2 == 1) ? 16'h0020 : 16'h0;
      step(1);
      saw = saw | key_sured | code_set;
    end
    keys = 16'h0;
    for (int t = 0; t < 64; t++) begin
      step(1);
      saw = saw | key_sured | code_set;
    end
    chk("bounce_strobe", int'(saw), 0);
    chk("bounce_kv", int'(key_value), int'(prev));

    // '1'+'2' held: rejected, then '2' alone
    align();
    keys = 16'h0003;
    saw = 1'b0;
    for (int t = 0; t < 64; t++) begin
      step(1);
      saw = saw | key_sured | code_set;
    end
    chk("multi_strobe", int'(saw), 0);
    chk("multi_kv", int'(key_value), int'(prev));
    press_check(16'h0002, prev, 4'h2, 1'b1, 1'b0);
    release_check(4'h2, 1'b1, 1'b0);

    // reset while '7' is held
    align();
    press_check(16'h0100, 4'h2, 4'h7, 1'b1, 1'b0);
    step(5);
    n_rst = 1'b0;
    #1;
    chk("arst_kv", int'(key_value), 0);
    chk("arst_sured", int'(key_sured), 0);
    chk("arst_col", int'(col_out), 14);
    step(2);
    n_rst = 1'b1;
    press_check(16'h0100, 4'h0, 4'h7, 1'b1, 1'b0);
    release_check(4'h7, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
